reg_dump_reader: RTL

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_pkg.sv | 27 ++
 rtl/reg_dump_reader_hex_to_ascii.sv | 22 ++
 rtl/reg_dump_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
// Shared definitions for the register dump reader: the FSM state enum,
// the ASCII constants used to build each dump line, and a helper that
// computes the line length for a given address/data width.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT,
        NEXT,
        FIN
    } state_t;

    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    // 'R' + address digits + ':' + data digits + CR + LF
    function automatic int line_len(input int addr_w, input int data_w);
        return 1 + (addr_w + 3) / 4 + 1 + data_w / 4 + 2;
    endfunction

endpackage

// File: rtl/reg_dump_reader_hex_to_ascii.sv
// hex_to_ascii
// Combinational conversion of one 4-bit nibble to its uppercase ASCII
// hex digit ('0'..'9', 'A'..'F').
// Ports:
//   nibble  in   4  value to convert
//   ascii   out  8  ASCII character
module hex_to_ascii
    import reg_dump_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// Walks every entry of a register file through a combinational read port
// and streams each one to a UART transmitter as a text line of the form
// "R<addr hex>:<data hex>\r\n". A snapshot of the entry is taken before
// its line is emitted, so later register writes cannot tear the line.
// Optional feature: define REG_DUMP_SKIP_ZERO_EN to suppress lines for
// registers whose value is zero.
// Ports:
//   clk       in   1       clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       dump request, ignored while a dump runs
//   ra        out  ADDR_W  register-file read address
//   rd        in   DATA_W  register-file read data for ra
//   tx_data   out  8       character offered to the transmitter
//   tx_valid  out  1       tx_data valid
//   tx_ready  in   1       transmitter accepts tx_data
//   busy      out  1       dump in progress
//   done      out  1       one-cycle pulse at dump end
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int AD       = (ADDR_W + 3) / 4;
    localparam int ND       = DATA_W / 4;
    localparam int LINE_LEN = line_len(ADDR_W, DATA_W);
    localparam int IDX_W    = $clog2(LINE_LEN);
    localparam int RA_EXT_W = 4 * AD;
    localparam logic [ADDR_W-1:0] RA_LAST = '1;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   snapshot;
    logic [IDX_W-1:0]    idx;
    logic                last_char;
    logic [RA_EXT_W-1:0] ra_ext;
    logic [RA_EXT_W-1:0] ra_shift;
    logic [DATA_W-1:0]   snap_shift;
    logic [3:0]          nibble;
    logic [7:0]          hex_ascii;
    logic [7:0]          char_sel;
    logic                use_hex;
    int                  pos;

    assign last_char = (int'(idx) == LINE_LEN - 1);
    assign ra_ext    = RA_EXT_W'(ra);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
`ifdef REG_DUMP_SKIP_ZERO_EN
            FETCH: state_next = (rd == '0) ? NEXT : EMIT;
`else
            FETCH: state_next = EMIT;
`endif
            EMIT:  if (tx_ready && last_char) state_next = NEXT;
            NEXT:  state_next = (ra == RA_LAST) ? FIN : FETCH;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address counter, snapshot and character index. ra deliberately stops
    // at the last entry instead of wrapping; NEXT leaves through FIN there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra       <= '0;
            snapshot <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE:  if (start) ra <= '0;
                FETCH: begin
                    snapshot <= rd;
                    idx      <= '0;
                end
                EMIT:  if (tx_ready && !last_char) idx <= idx + IDX_W'(1);
                NEXT:  if (ra != RA_LAST) ra <= ra + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // Character selection by index: fixed punctuation or a hex digit taken
    // MSB-first from either the zero-extended address or the snapshot.
    always_comb begin
        pos        = int'(idx);
        char_sel   = ASCII_R;
        use_hex    = 1'b0;
        ra_shift   = '0;
        snap_shift = '0;
        nibble     = 4'h0;
        if (pos == 0) begin
            char_sel = ASCII_R;
        end else if (pos <= AD) begin
            use_hex  = 1'b1;
            ra_shift = ra_ext >> (4 * (AD - pos));
            nibble   = ra_shift[3:0];
        end else if (pos == AD + 1) begin
            char_sel = ASCII_COLON;
        end else if (pos <= AD + 1 + ND) begin
            use_hex    = 1'b1;
            snap_shift = snapshot >> (4 * (AD + 1 + ND - pos));
            nibble     = snap_shift[3:0];
        end else if (pos == AD + 2 + ND) begin
            char_sel = ASCII_CR;
        end else begin
            char_sel = ASCII_LF;
        end
    end

    hex_to_ascii u_hex_to_ascii (
        .nibble (nibble),
        .ascii  (hex_ascii)
    );

    // busy drops in FIN, the same cycle done pulses.
    always_comb begin
        tx_valid = (state == EMIT);
        tx_data  = 8'h00;
        if (state == EMIT) begin
            tx_data = use_hex ? hex_ascii : char_sel;
        end
        busy = (state == FETCH) || (state == EMIT) || (state == NEXT);
        done = (state == FIN);
    end

endmodule
